// File: rtl/cam_line_packer.sv
// cam_line_packer: packs camera pixels into fixed-length flagged lines for the SDRAM write FIFO,
// padding short lines and dropping the excess of long ones so every line fills whole bursts.
module cam_line_packer #(
  parameter int p_dram_dataw = 16,
  parameter int p_line_words = 640,
  parameter int p_frame_lines = 480,
  parameter int p_dram_burst_size = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [p_dram_dataw-1:0] i_data,
  input  logic                    i_sof,
  input  logic                    i_eol,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [p_dram_dataw+1:0] o_data,
  input  logic                    i_ready,
  output logic                    o_frame_active,
  output logic [7:0]              o_err_count
);
  localparam int cw = p_line_words > 1 ? $clog2(p_line_words) : 1;
  localparam int rw = p_frame_lines > 1 ? $clog2(p_frame_lines) : 1;
  localparam logic [cw-1:0] last_col = cw'(p_line_words - 1);
  localparam logic [rw-1:0] last_row = rw'(p_frame_lines - 1);

  if (p_line_words % p_dram_burst_size != 0) begin : g_bad_line
    $error("p_line_words must be a multiple of p_dram_burst_size");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DISCARD} state_t;
  state_t state, state_nx;
  logic [cw-1:0] col, col_nx, c;
  logic [rw-1:0] row, row_nx, r;
  logic free, acc, start, take, pad_emit, emit, eol_eff, err_inc;
  logic [p_dram_dataw+1:0] word;

  // A sof arriving mid-line is held off (ready low) until padding closes the line.
  always_comb begin
    free = ~o_valid | i_ready;
    o_ready = state == PAD ? 1'b0 :
              state == DISCARD ? (~i_sof | free) :
              state == ACTIVE ? (free & ~(i_sof & col != '0)) : free;
    acc = i_valid & o_ready;
    start = acc & i_sof;
    take = start | (acc & state == ACTIVE);
    pad_emit = (state == PAD) & free;
    emit = take | pad_emit;
    eol_eff = pad_emit | i_eol;
    c = start ? '0 : col;
    r = start ? '0 : row;
    word = {pad_emit ? {p_dram_dataw{1'b0}} : i_data, start ? 2'b11 : {1'b0, c == '0}};
    state_nx = state;
    col_nx = col;
    row_nx = row;
    err_inc = 1'b0;
    if (emit && c == last_col) begin
      col_nx = '0;
      row_nx = (r == last_row) ? '0 : r + 1'b1;
      state_nx = (r == last_row) ? IDLE : eol_eff ? ACTIVE : DISCARD;
      err_inc = (r != last_row) & ~eol_eff;
    end else if (emit) begin
      col_nx = c + 1'b1;
      row_nx = r;
      state_nx = eol_eff ? PAD : ACTIVE;
      err_inc = ~pad_emit & i_eol;
    end else if (acc && state == DISCARD && i_eol) begin
      state_nx = ACTIVE;
    end else if (state == ACTIVE && i_valid && i_sof && col != '0) begin
      state_nx = PAD;
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_err_count <= '0;
    end else begin
      state <= state_nx;
      col <= col_nx;
      row <= row_nx;
      if (emit) begin
        o_valid <= 1'b1;
        o_data <= word;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (err_inc && o_err_count != 8'hff) o_err_count <= o_err_count + 8'd1;
    end
  end

  assign o_frame_active = state != IDLE;
endmodule

// File: tb/tb_cam_line_packer.sv
// tb_cam_line_packer: directed and randomized frames scored against a line-level reference model.
module tb_cam_line_packer;
  localparam int W = 16;
  localparam int L = 8;
  localparam int F = 2;
  localparam int M_IDLE = 0, M_ACT = 1, M_DISC = 2;

  logic clk, i_rst_n, i_valid, i_sof, i_eol, i_ready;
  logic [W-1:0] i_data;
  logic o_ready, o_valid, o_frame_active;
  logic [W+1:0] o_data;
  logic [7:0] o_err_count;

  int n_chk = 0, n_err = 0;
  int bp_mode = 1;
  logic [W+1:0] q[$];
  int m_mode = M_IDLE, m_pos = 0, m_line = 0, m_err = 0;
  logic stall;
  logic [W+1:0] hold_d;

  cam_line_packer #(.p_dram_dataw(W), .p_line_words(L), .p_frame_lines(F), .p_dram_burst_size(8)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data), .i_sof(i_sof), .i_eol(i_eol),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_frame_active(o_frame_active), .o_err_count(o_err_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int e);
    return e > 255 ? 255 : e;
  endfunction

  // Reference model: works on whole lines -- a line closes after exactly L words,
  // short lines are filled with zeros, overlong lines are dropped up to the next eol.
  task automatic m_emit(input logic [W-1:0] d, input logic [1:0] f);
    q.push_back({d, f});
    m_pos++;
  endtask

  task automatic m_close(input bit eol);
    m_pos = 0;
    m_line++;
    if (m_line == F) m_mode = M_IDLE;
    else if (!eol) begin
      m_mode = M_DISC;
      m_err++;
    end else m_mode = M_ACT;
  endtask

  task automatic m_fill();
    m_err++;
    while (m_pos < L) m_emit('0, 2'b00);
    m_close(1);
  endtask

  task automatic m_after(input bit eol);
    if (m_pos == L) m_close(eol);
    else if (eol) m_fill();
  endtask

  task automatic model(input logic [W-1:0] d, input bit s, input bit e);
    if (s && m_mode == M_ACT && m_pos != 0) m_fill();
    if (s) begin
      m_mode = M_ACT;
      m_line = 0;
      m_pos = 0;
      m_emit(d, 2'b11);
      m_after(e);
    end else if (m_mode == M_ACT) begin
      m_emit(d, m_pos == 0 ? 2'b01 : 2'b00);
      m_after(e);
    end else if (m_mode == M_DISC && e) m_mode = M_ACT;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bp_mode == 0) i_ready = $urandom_range(0, 3) != 0;
    end
  end

  // Scoreboard: sampled just before each rising edge.
  initial begin
    stall = 0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!i_rst_n) stall = 0;
      else begin
        if (stall) check("hold", {o_valid, o_data}, {1'b1, hold_d});
        if (o_valid && i_ready) begin
          check("word_expected", q.size() != 0, 1);
          if (q.size() != 0) check("word", o_data, q.pop_front());
        end
        stall = o_valid & ~i_ready;
        hold_d = o_data;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit s, input bit e, output int waits);
    model(d, s, e);
    i_valid = 1;
    i_data = d;
    i_sof = s;
    i_eol = e;
    waits = 0;
    #4;
    while (!o_ready) begin
      @(negedge clk);
      #4;
      waits++;
      if (waits > 200) begin
        $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
        $fatal(1);
      end
    end
    @(negedge clk);
    i_valid = 0;
    i_sof = 0;
    i_eol = 0;
  endtask

  task automatic send_line(input bit sof, input int len, input int gap);
    int w;
    for (int p = 0; p < len; p++) begin
      send(W'($urandom), sof && p == 0, p == len - 1, w);
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    i_valid = 0;
    while ((q.size() != 0 || o_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, q.size(), 0);
    check({tag, "_err"}, o_err_count, sat(m_err));
    check({tag, "_active"}, o_frame_active, m_mode != M_IDLE);
  endtask

  task automatic do_reset(input string tag);
    i_valid = 0;
    i_sof = 0;
    i_eol = 0;
    i_rst_n = 0;
    #1;
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_err"}, o_err_count, 0);
    check({tag, "_active"}, o_frame_active, 0);
    check({tag, "_ready"}, o_ready, 1);
    q.delete();
    m_mode = M_IDLE;
    m_pos = 0;
    m_line = 0;
    m_err = 0;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1;
  endtask

  initial begin
    int w;
    bit abort;
    i_rst_n = 0;
    i_valid = 0;
    i_sof = 0;
    i_eol = 0;
    i_data = '0;
    i_ready = 1;
    @(negedge clk);
    do_reset("rst0");

    send_line(1, 8, 0);
    send_line(0, 8, 0);
    drain("nominal");

    do_reset("rst1");
    send_line(1, 5, 0);
    send(W'($urandom), 0, 0, w);
    check("pad_wait", w, 3);
    send_line(0, 7, 0);
    drain("short");

    do_reset("rst2");
    send_line(1, 11, 1);
    send_line(0, 8, 1);
    drain("long");

    do_reset("rst3");
    send_line(1, 3, 0);
    send(W'($urandom), 0, 0, w);
    i_ready = 0;
    i_valid = 1;
    i_data = '0;
    repeat (5) begin
      #4;
      check("bp_ready", o_ready, 0);
      @(negedge clk);
    end
    i_ready = 1;
    send(W'($urandom), 0, 0, w);
    send_line(0, 3, 0);
    send_line(0, 8, 0);
    drain("backpressure");

    do_reset("rst4");
    for (int p = 0; p < 3; p++) send(W'($urandom), p == 0, 0, w);
    send_line(1, 8, 0);
    send_line(0, 8, 0);
    drain("midsof");

    do_reset("rst5");
    for (int p = 0; p < 3; p++) send(W'($urandom), 0, p == 2, w);
    for (int p = 0; p < 4; p++) send(W'($urandom), p == 0, 0, w);
    do_reset("rst_mid");
    send(W'($urandom), 0, 1, w);
    send_line(1, 8, 0);
    send_line(0, 8, 0);
    drain("presof");

    bp_mode = 0;
    for (int f = 0; f < 40; f++) begin
      abort = 0;
      repeat ($urandom_range(0, 2)) send(W'($urandom), 0, $urandom_range(0, 3) == 0, w);
      for (int ln = 0; ln < F && !abort; ln++) begin
        int len;
        len = $urandom_range(0, 9) < 6 ? L : $urandom_range(1, 12);
        abort = $urandom_range(0, 9) == 0;
        for (int p = 0; p < (abort ? len / 2 + 1 : len); p++) begin
          send(W'($urandom), ln == 0 && p == 0, !abort && p == len - 1, w);
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
      end
    end
    bp_mode = 1;
    i_ready = 1;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
